// File: rtl/letreiro_pkg.sv
// Shared types for the sign lamp driver: per-lamp fade states and word bits.
package letreiro_pkg;

    typedef enum logic [1:0] {
        APAGADA,
        ACENDENDO,
        ACESA,
        APAGANDO
    } estado_lampada_t;

    localparam int BAR   = 2;
    localparam int MOSCA = 1;
    localparam int AZUL  = 0;

endpackage

// File: rtl/canal_lampada.sv
// One lamp channel: fade FSM, brightness register and PWM compare.
// CONTADOR_ACENDIMENTOS_EN adds a saturating count of completed fade-ins.
module canal_lampada
    import letreiro_pkg::*;
#(
    parameter int PWM_BITS = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                alvo,
    input  logic                tick,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic                lampada,
    output logic [PWM_BITS-1:0] brilho,
`ifdef CONTADOR_ACENDIMENTOS_EN
    output logic [7:0]          acendimentos,
`endif
    output logic                estavel
);

    localparam logic [PWM_BITS-1:0] MAX  = '1;
    localparam logic [PWM_BITS-1:0] ZERO = '0;
    localparam logic [PWM_BITS-1:0] UM   = PWM_BITS'(1);

    estado_lampada_t     estado_q, estado_d;
    logic [PWM_BITS-1:0] brilho_q, brilho_d;
    logic                lampada_q, lampada_d;

    // A reversal of alvo changes direction only; the step waits for a later tick.
    always_comb begin
        estado_d = estado_q;
        brilho_d = brilho_q;
        unique case (estado_q)
            APAGADA: begin
                if (alvo) estado_d = ACENDENDO;
            end
            ACENDENDO: begin
                if (!alvo) begin
                    estado_d = APAGANDO;
                end else if (tick) begin
                    if (brilho_q != MAX) brilho_d = brilho_q + UM;
                    if (brilho_d == MAX) estado_d = ACESA;
                end
            end
            ACESA: begin
                if (!alvo) estado_d = APAGANDO;
            end
            APAGANDO: begin
                if (alvo) begin
                    estado_d = ACENDENDO;
                end else if (tick) begin
                    if (brilho_q != ZERO) brilho_d = brilho_q - UM;
                    if (brilho_d == ZERO) estado_d = APAGADA;
                end
            end
        endcase
    end

    // Full brightness is a solid on rather than MAX/(MAX+1) duty.
    always_comb begin
        lampada_d = 1'b0;
        if (brilho_q == MAX) begin
            lampada_d = 1'b1;
        end else if (brilho_q != ZERO) begin
            lampada_d = (pwm_cnt < brilho_q);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q  <= APAGADA;
            brilho_q  <= ZERO;
            lampada_q <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            brilho_q  <= brilho_d;
            lampada_q <= lampada_d;
        end
    end

`ifdef CONTADOR_ACENDIMENTOS_EN
    logic [7:0] acend_q, acend_d;

    always_comb begin
        acend_d = acend_q;
        if (estado_q == ACENDENDO && estado_d == ACESA && acend_q != 8'hFF) begin
            acend_d = acend_q + 8'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acend_q <= 8'd0;
        end else begin
            acend_q <= acend_d;
        end
    end

    assign acendimentos = acend_q;
`endif

    assign lampada = lampada_q;
    assign brilho  = brilho_q;
    assign estavel = (estado_q == APAGADA) || (estado_q == ACESA);

endmodule

// File: rtl/driver_lampadas.sv
// Sign lamp driver: shared ramp divider and PWM counter feeding per-word fade channels.
// CONTADOR_ACENDIMENTOS_EN adds the acendimentos counter output.
module driver_lampadas
    import letreiro_pkg::*;
#(
    parameter int PWM_BITS  = 4,
    parameter int RAMP_DIV  = 4,
    parameter int NUM_LAMPS = 3
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          liga,
    input  logic [NUM_LAMPS-1:0]          palavras,
    output logic [NUM_LAMPS-1:0]          lampadas,
    output logic                          estavel,
`ifdef CONTADOR_ACENDIMENTOS_EN
    output logic [NUM_LAMPS*8-1:0]        acendimentos,
`endif
    output logic [NUM_LAMPS*PWM_BITS-1:0] brilho
);

    localparam int DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_FIM = DIV_W'(RAMP_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_UM  = DIV_W'(1);
    localparam logic [PWM_BITS-1:0] PWM_UM = PWM_BITS'(1);

    logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic                tick;
    logic [NUM_LAMPS-1:0] alvo;
    logic [NUM_LAMPS-1:0] estavel_canal;

    always_comb begin
        tick      = (div_cnt_q == DIV_FIM);
        div_cnt_d = tick ? '0 : div_cnt_q + DIV_UM;
        pwm_cnt_d = pwm_cnt_q + PWM_UM;
        alvo      = palavras & {NUM_LAMPS{liga}};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_cnt_q <= '0;
            pwm_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
            pwm_cnt_q <= pwm_cnt_d;
        end
    end

    for (genvar i = 0; i < NUM_LAMPS; i++) begin : g_canal
        canal_lampada #(
            .PWM_BITS(PWM_BITS)
        ) u_canal (
            .clock       (clock),
            .reset       (reset),
            .alvo        (alvo[i]),
            .tick        (tick),
            .pwm_cnt     (pwm_cnt_q),
            .lampada     (lampadas[i]),
            .brilho      (brilho[i*PWM_BITS +: PWM_BITS]),
`ifdef CONTADOR_ACENDIMENTOS_EN
            .acendimentos(acendimentos[i*8 +: 8]),
`endif
            .estavel     (estavel_canal[i])
        );
    end

    assign estavel = &estavel_canal;

endmodule

// File: tb/tb_driver_lampadas.sv
// Randomized and directed bench for driver_lampadas against a fade-toward-target model.
module tb_driver_lampadas;
    import letreiro_pkg::*;

    localparam int RD   = 4;
    localparam int MAXV = 15;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        liga = 1'b0;
    logic [2:0]  palavras = 3'b000;
    logic [2:0]  lampadas;
    logic        estavel;
    logic [11:0] brilho;
`ifdef CONTADOR_ACENDIMENTOS_EN
    logic [23:0] acendimentos;
`endif

    int vectors = 0;
    int miscompares = 0;

    // Model: brightness walks one step per tick toward the target level, but
    // only once the target has been steady for a clock; a channel is settled
    // once a tick has left it at its target level.
    int b[3];
    bit ult[3];
    bit assent[3];
    bit lamp_m[3];
    int cyc;

    driver_lampadas dut (
        .clock       (clock),
        .reset       (reset),
        .liga        (liga),
        .palavras    (palavras),
        .lampadas    (lampadas),
        .estavel     (estavel),
`ifdef CONTADOR_ACENDIMENTOS_EN
        .acendimentos(acendimentos),
`endif
        .brilho      (brilho)
    );

    always #5 clock = ~clock;

    task automatic verifica(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic modelo_reset();
        for (int i = 0; i < 3; i++) begin
            b[i] = 0;
            ult[i] = 1'b0;
            assent[i] = 1'b1;
            lamp_m[i] = 1'b0;
        end
        cyc = 0;
    endtask

    task automatic modelo_borda();
        bit tk;
        bit a;
        int pwm;
        tk = (cyc % RD) == RD - 1;
        pwm = cyc % (MAXV + 1);
        for (int i = 0; i < 3; i++) begin
            if (b[i] == MAXV) lamp_m[i] = 1'b1;
            else if (b[i] == 0) lamp_m[i] = 1'b0;
            else lamp_m[i] = pwm < b[i];
            a = palavras[i] & liga;
            if (a != ult[i]) begin
                assent[i] = 1'b0;
            end else if (tk) begin
                if (a) b[i] = (b[i] < MAXV) ? b[i] + 1 : MAXV;
                else b[i] = (b[i] > 0) ? b[i] - 1 : 0;
                if (b[i] == (a ? MAXV : 0)) assent[i] = 1'b1;
            end
            ult[i] = a;
        end
        cyc++;
    endtask

    task automatic confere_tudo();
        logic [11:0] eb;
        eb = {4'(b[2]), 4'(b[1]), 4'(b[0])};
        verifica("brilho", {20'd0, brilho}, {20'd0, eb});
        verifica("lampadas", {29'd0, lampadas},
                 {29'd0, lamp_m[2], lamp_m[1], lamp_m[0]});
        verifica("estavel", {31'd0, estavel},
                 {31'd0, assent[0] & assent[1] & assent[2]});
    endtask

    task automatic ciclo(input logic l, input logic [2:0] p);
        liga = l;
        palavras = p;
        @(posedge clock);
        modelo_borda();
        @(negedge clock);
        confere_tudo();
    endtask

    initial begin
        int n;
        int altos;
        logic l;
        logic [2:0] p;

        modelo_reset();
        repeat (3) begin
            @(negedge clock);
            confere_tudo();
        end
        reset = 1'b0;

        repeat (100) ciclo(1'b0, 3'b000);

        repeat (60) ciclo(1'b1, 3'b100);
        verifica("bar_cheio", {28'd0, brilho[BAR*4 +: 4]}, 32'd15);
        verifica("bar_estavel", {31'd0, estavel}, 32'd1);
        repeat (20) ciclo(1'b1, 3'b100);
        verifica("bar_solido", {31'd0, lampadas[BAR]}, 32'd1);

        repeat (70) ciclo(1'b1, 3'b000);
        n = 0;
        while (b[BAR] != 5 && n < 100) begin
            ciclo(1'b1, 3'b100);
            n++;
        end
        verifica("bar_em_5", {28'd0, brilho[BAR*4 +: 4]}, 32'd5);
        // Toggling the target every clock keeps the level frozen.
        for (int k = 0; k < 2; k++) ciclo(1'b1, (k % 2) ? 3'b100 : 3'b000);
        altos = 0;
        for (int k = 2; k < 18; k++) begin
            ciclo(1'b1, (k % 2) ? 3'b100 : 3'b000);
            if (lampadas[BAR]) altos++;
        end
        verifica("duty_5_16", altos, 32'd5);
        repeat (40) ciclo(1'b1, 3'b000);

        n = 0;
        while (b[MOSCA] != 7 && n < 100) begin
            ciclo(1'b1, 3'b010);
            n++;
        end
        verifica("mosca_em_7", {28'd0, brilho[MOSCA*4 +: 4]}, 32'd7);
        ciclo(1'b1, 3'b000);
        verifica("mosca_retida", {28'd0, brilho[MOSCA*4 +: 4]}, 32'd7);
        repeat (32) ciclo(1'b1, 3'b000);
        verifica("mosca_apagada", {28'd0, brilho[MOSCA*4 +: 4]}, 32'd0);

        repeat (70) ciclo(1'b1, 3'b111);
        verifica("todas_cheias", {20'd0, brilho}, 32'hFFF);
        repeat (64) ciclo(1'b0, 3'($urandom));
        verifica("liga_apagou", {20'd0, brilho}, 32'd0);
        verifica("liga_estavel", {31'd0, estavel}, 32'd1);

        n = 0;
        while (b[BAR] != 9 && n < 100) begin
            ciclo(1'b1, 3'b100);
            n++;
        end
        verifica("bar_em_9", {28'd0, brilho[BAR*4 +: 4]}, 32'd9);
        #2 reset = 1'b1;
        #1;
        verifica("rst_brilho", {20'd0, brilho}, 32'd0);
        verifica("rst_lampadas", {29'd0, lampadas}, 32'd0);
        verifica("rst_estavel", {31'd0, estavel}, 32'd1);
        modelo_reset();
        @(negedge clock);
        confere_tudo();
        reset = 1'b0;

        repeat (60) begin
            l = ($urandom_range(0, 3) != 0);
            p = 3'($urandom);
            n = $urandom_range(1, 50);
            repeat (n) ciclo(l, p);
        end
        repeat (200) ciclo(1'($urandom), 3'($urandom));

`ifdef CONTADOR_ACENDIMENTOS_EN
        repeat (300) begin
            repeat (64) ciclo(1'b1, 3'b100);
            repeat (64) ciclo(1'b1, 3'b000);
        end
        verifica("acend_sat", {24'd0, acendimentos[BAR*8 +: 8]}, 32'd255);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
